// File: rtl/nibble_alu_sequencer.sv
// Two-requester 8-bit ALU that time-shares one external 4-bit adder, doing the
// low nibble then the high nibble, with round-robin arbitration between requesters.
module nibble_alu_sequencer #(
   parameter logic RR_INIT = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic [1:0] op0,
   input  logic [1:0] op1,
   input  logic [7:0] a0,
   input  logic [7:0] b0,
   input  logic [7:0] a1,
   input  logic [7:0] b1,
   output logic       ack0,
   output logic       ack1,
   output logic [7:0] result,
   output logic       carry,
   output logic       zero,
   output logic       busy,
   output logic [3:0] add_a,
   output logic [3:0] add_b,
   output logic       add_cin,
   input  logic [3:0] add_sum,
   input  logic       add_cout
);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_NEG = 2'b10;

   state_t     state_q, state_d;
   logic       rr_q, rr_d;
   logic       gid_q, gid_d;
   logic [1:0] op_q, op_d;
   logic [7:0] a_q, a_d, b_q, b_d;
   logic       cy_q, cy_d;
   logic [7:0] res_q, res_d;
   logic       carry_q, carry_d;
   logic       zero_q, zero_d;
   logic       gnt1;
   logic [3:0] an, bn;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rr_q    <= RR_INIT;
         gid_q   <= 1'b0;
         op_q    <= 2'b00;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         cy_q    <= 1'b0;
         res_q   <= 8'h00;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         gid_q   <= gid_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cy_q    <= cy_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
      end
   end

   // Requester 1 wins when it is alone, or when both ask and the pointer names it.
   assign gnt1 = req1 & (~req0 | rr_q);
   assign an   = (state_q == HIGH) ? a_q[7:4] : a_q[3:0];
   assign bn   = (state_q == HIGH) ? b_q[7:4] : b_q[3:0];

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      gid_d   = gid_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      cy_d    = cy_q;
      res_d   = res_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      add_a   = 4'h0;
      add_b   = 4'h0;
      add_cin = 1'b0;
      if (state_q == LOW || state_q == HIGH) begin
         add_a = (op_q == OP_NEG) ? ~an : an;
         case (op_q)
            OP_ADD:  add_b = bn;
            OP_SUB:  add_b = ~bn;
            default: add_b = 4'h0;
         endcase
         add_cin = (state_q == LOW) ? (op_q != OP_ADD) : cy_q;
      end
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               state_d = LOW;
               gid_d   = gnt1;
               rr_d    = ~gnt1;
               op_d    = gnt1 ? op1 : op0;
               a_d     = gnt1 ? a1 : a0;
               b_d     = gnt1 ? b1 : b0;
            end
         end
         LOW: begin
            state_d    = HIGH;
            cy_d       = add_cout;
            res_d[3:0] = add_sum;
         end
         HIGH: begin
            state_d    = DONE;
            res_d[7:4] = add_sum;
            carry_d    = add_cout;
            zero_d     = ({add_sum, res_q[3:0]} == 8'h00);
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy   = (state_q != IDLE);
   assign ack0   = (state_q == DONE) & ~gid_q;
   assign ack1   = (state_q == DONE) & gid_q;
   assign result = res_q;
   assign carry  = carry_q;
   assign zero   = zero_q;

endmodule

// File: tb/tb_nibble_alu_sequencer.sv
// Directed bench for nibble_alu_sequencer; the shared 4-bit adder is modelled
// here as plain combinational addition.
module tb_nibble_alu_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [1:0] op0 = 2'b00, op1 = 2'b00;
   logic [7:0] a0 = 8'h00, b0 = 8'h00, a1 = 8'h00, b1 = 8'h00;
   logic       ack0, ack1, carry, zero, busy, add_cin, add_cout;
   logic [7:0] result;
   logic [3:0] add_a, add_b, add_sum;

   int n_vec = 0;
   int n_err = 0;

   nibble_alu_sequencer #(.RR_INIT(1'b0)) dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1),
      .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .ack0(ack0), .ack1(ack1), .result(result), .carry(carry), .zero(zero),
      .busy(busy), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout)
   );

   always #5 clk = ~clk;

   always_comb {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_cin};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Issue one request at a negedge (cycle 0) and check LOW nibble drive,
   // ack in cycle 3 and the results; exp_low = {add_a, add_b, add_cin} in LOW.
   task automatic run_op(input string tag, input bit id, input logic [1:0] op,
                         input logic [7:0] a, input logic [7:0] b, input bit mut,
                         input logic [8:0] exp_low, input logic [7:0] er,
                         input logic ec, input logic ez);
      if (id) begin op1 = op; a1 = a; b1 = b; req1 = 1'b1; end
      else    begin op0 = op; a0 = a; b0 = b; req0 = 1'b1; end
      step();
      chk({tag, " busy LOW"}, {31'd0, busy}, 32'd1);
      chk({tag, " low drive"}, {23'd0, add_a, add_b, add_cin}, {23'd0, exp_low});
      if (mut) begin a0 = 8'hFF; b0 = 8'hFF; a1 = 8'hFF; b1 = 8'hFF; end
      step();
      chk({tag, " no ack HIGH"}, {30'd0, ack1, ack0}, 32'd0);
      step();
      chk({tag, " ack"}, {30'd0, ack1, ack0}, id ? 32'd2 : 32'd1);
      chk({tag, " result"}, {22'd0, result, carry, zero}, {22'd0, er, ec, ez});
      req0 = 1'b0;
      req1 = 1'b0;
      step();
      chk({tag, " idle"}, {22'd0, ack1, ack0, busy, add_a, add_b, add_cin},
          {22'd0, 13'd0});
   endtask

   initial begin
      step();
      step();
      chk("reset outs", {16'd0, result, carry, zero, ack0, ack1, busy, add_cin, 2'b00},
          32'd0);
      reset = 1'b0;
      step();

      run_op("add",    1'b0, 2'b00, 8'h3C, 8'h49, 1'b0, {4'hC, 4'h9, 1'b0}, 8'h85, 1'b0, 1'b0);
      run_op("sub0",   1'b1, 2'b01, 8'h10, 8'h10, 1'b0, {4'h0, 4'hF, 1'b1}, 8'h00, 1'b1, 1'b1);
      run_op("subneg", 1'b1, 2'b01, 8'h05, 8'h06, 1'b0, {4'h5, 4'h9, 1'b1}, 8'hFF, 1'b0, 1'b0);
      run_op("neg1",   1'b0, 2'b10, 8'h01, 8'hAA, 1'b0, {4'hE, 4'h0, 1'b1}, 8'hFF, 1'b0, 1'b0);
      run_op("neg0",   1'b0, 2'b10, 8'h00, 8'h55, 1'b0, {4'hF, 4'h0, 1'b1}, 8'h00, 1'b1, 1'b1);
      run_op("incff",  1'b1, 2'b11, 8'hFF, 8'h33, 1'b0, {4'hF, 4'h0, 1'b1}, 8'h00, 1'b1, 1'b1);
      run_op("inc7f",  1'b0, 2'b11, 8'h7F, 8'h00, 1'b0, {4'hF, 4'h0, 1'b1}, 8'h80, 1'b0, 1'b0);
      run_op("latch",  1'b0, 2'b00, 8'h12, 8'h34, 1'b1, {4'h2, 4'h4, 1'b0}, 8'h46, 1'b0, 1'b0);

      // Round robin from a fresh reset: both held, each drops req only after its ack.
      reset = 1'b1;
      step();
      reset = 1'b0;
      op0 = 2'b00; a0 = 8'h01; b0 = 8'h02;
      op1 = 2'b11; a1 = 8'h10; b1 = 8'h00;
      req0 = 1'b1; req1 = 1'b1;
      for (int g = 0; g < 4; g++) begin
         step(); step(); step();
         chk($sformatf("rr grant %0d", g), {30'd0, ack1, ack0}, (g % 2) ? 32'd2 : 32'd1);
         chk($sformatf("rr res %0d", g), {24'd0, result}, (g % 2) ? 32'h11 : 32'h03);
         if (g % 2) req1 = 1'b0; else req0 = 1'b0;
         step();
         req0 = 1'b1; req1 = 1'b1;
      end
      req0 = 1'b0; req1 = 1'b0;
      step(); step(); step(); step();

      // Reset during HIGH aborts; held req is granted in the first IDLE after release.
      op0 = 2'b00; a0 = 8'h21; b0 = 8'h43;
      req0 = 1'b1;
      step();
      step();
      chk("abort in HIGH", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      step();
      chk("abort outs", {22'd0, result, ack1, ack0, busy}, 32'd0);
      reset = 1'b0;
      step();
      chk("regrant busy", {31'd0, busy}, 32'd1);
      step();
      step();
      chk("regrant ack", {30'd0, ack1, ack0}, 32'd1);
      chk("regrant res", {24'd0, result}, 32'h64);
      req0 = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/nibble_alu_sequencer.md
NIBBLE_ALU_SEQUENCER -- requirements
Module: nibble_alu_sequencer

Interface
REQ-001 Parameter RR_INIT, default 0: round-robin pointer value loaded at reset (0 = requester 0 wins first tie, 1 = requester 1 wins).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0 / req1  input  1 each  request from requester 0 / 1, held high until the matching ack is seen.
REQ-005 op0 / op1  input  2 each  operation: 00 ADD (a+b), 01 SUB (a-b), 10 NEG (-a, b ignored), 11 INC (a+1, b ignored).
REQ-006 a0, b0 / a1, b1  input  8 each  operands for requester 0 / 1.
REQ-007 ack0 / ack1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-008 result  output  8  8-bit result.
REQ-009 carry  output  1  carry out of bit 7.
REQ-010 zero  output  1  high when result is 0x00.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 add_a, add_b  output  4 each  operands driven to the shared external 4-bit CLA adder.
REQ-013 add_cin  output  1  carry-in driven to the shared adder.
REQ-014 add_sum  input  4  adder sum, combinational, valid in the same cycle.
REQ-015 add_cout  input  1  adder carry-out, combinational, valid in the same cycle.

Function
REQ-016 FSM states and transitions:
- IDLE -> LOW when any req is high.
- LOW -> HIGH, HIGH -> DONE and DONE -> IDLE unconditionally.
REQ-017 Grant in IDLE:
- Only one req high: that requester is granted.
- Both high: the requester named by the round-robin pointer is granted.
- After every grant the pointer is set to the non-granted requester.
REQ-018 On the grant edge the block latches op, a, b and the grant id; later changes on the operand inputs are ignored until the next grant.
REQ-019 Nibble operand selection, where n is the current nibble (LOW: bits [3:0], HIGH: bits [7:4]):
- add_a = a[n], or ~a[n] for NEG.
- add_b = b[n] for ADD, ~b[n] for SUB, 0000 for NEG/INC.
REQ-020 add_cin in LOW is 0 for ADD and 1 for SUB/NEG/INC; add_cin in HIGH is the add_cout registered at the end of LOW.
REQ-021 At the end of LOW, add_sum is captured into result bits [3:0]; at the end of HIGH, add_sum is captured into bits [7:4] and add_cout into carry.
REQ-022 In IDLE and DONE, add_a, add_b and add_cin are driven to 0.
REQ-023 Status flags:
- carry is the raw bit-7 carry; for SUB, 1 means no borrow.
- zero is updated together with carry.
REQ-024 In DONE, ack of the granted requester is high for exactly one cycle; the other ack is low. The acks are never both high.
REQ-025 Latency: req sampled in IDLE at cycle 0 -> ack high in cycle 3; throughput is one operation per 4 cycles.
REQ-026 Requester handshake:
- The requester drops req at the edge where it samples ack high.
- A req that is high in IDLE is always treated as a new request.
REQ-027 result, carry and zero are valid from the DONE cycle and hold until the next LOW/HIGH capture. The high nibble and flags are stable until the next HIGH.

Reset
REQ-028 While reset is high at an edge:
- state <= IDLE, ack0/ack1 <= 0, busy <= 0.
- result <= 0x00, carry <= 0, zero <= 0.
- internal carry and operand latches <= 0, pointer <= RR_INIT.
REQ-029 Reset in LOW, HIGH or DONE aborts the operation: no ack is issued and the pending request is re-arbitrated only after reset is released.

Verification
REQ-030 req0 ADD a=0x3C b=0x49 -> ack0 in cycle 3, result 0x85, carry 0, zero 0; during LOW add_a=C, add_b=9, cin=0.
REQ-031 req1 SUB 0x10-0x10 -> ack1 in cycle 3, result 0x00, carry 1, zero 1; SUB 0x05-0x06 -> 0xFF, carry 0.
REQ-032 Negate and increment edge cases:
- NEG 0x01 -> 0xFF, carry 0.
- NEG 0x00 -> 0x00, carry 1, zero 1.
- INC 0xFF -> 0x00, carry 1, zero 1.
- INC 0x7F -> 0x80.
REQ-033 RR_INIT=0, req0 and req1 rise together after reset:
- ack0 in cycle 3, ack1 in cycle 7.
- With both held continuously, grants alternate 0,1,0,1.
- Each requester drops req only for the cycle after its own ack, then raises it again.
REQ-034 Reset asserted during HIGH -> no ack, busy 0 and result 0x00 the cycle after the reset edge; a held req is granted in the first IDLE after reset falls.
REQ-035 Change a0/b0 in the cycle after the grant -> result reflects the operands latched at the grant.
